aes_lat_monitor: RTL and testbench
==================================

# aes_lat_monitor

Synthesizable, parametrised latency monitor for AES cores that use a start/done handshake. It watches NCH independent start/done channels and measures each transaction's start-to-done latency in cycles. Per channel it keeps min, max, sum and count statistics, an optional histogram, and sticky timeout and protocol-error flags. It sits beside aes_top instances, or a multi-core AES array, and makes the stall/latency statistics readable on silicon or FPGA as well as in simulation.

## Interface
- NCH, 1: number of monitored start/done channels.
- CNT_W, 16: latency counter width; the counter saturates at 2^CNT_W-1.
- SUM_W, 32: latency sum width; the sum saturates.
- TXN_W, 16: transaction count width; the count saturates.
- NBINS, 64: histogram bins; bin NBINS-1 also collects every latency ≥ NBINS-1.
- BIN_W, 16: histogram bin counter width; bin counters saturate.
- TIMEOUT, 2000: cycles without done before a transaction is declared timed out. Must be less than 2^CNT_W.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  NCH  per-channel start pulse, as driven to the AES core.
- done  in  NCH  per-channel done pulse from the AES core.
- clear  in  1  synchronous clear of all statistics, flags and FSMs.
- rd_ch  in  $clog2(NCH)+1  channel selected for readback.
- rd_bin  in  $clog2(NBINS)  histogram bin selected for readback.
- mon_busy  out  NCH  channel FSM is in MEAS.
- timeout_flag  out  NCH  sticky; the channel timed out.
- proto_err  out  NCH  sticky; start seen while busy, or done seen while IDLE.
- last_valid  out  NCH  1-cycle pulse when a latency is recorded.
- last_lat  out  NCH*CNT_W  most recently recorded latency, per channel.
- lat_min  out  CNT_W  minimum latency of the rd_ch channel.
- lat_max  out  CNT_W  maximum latency of the rd_ch channel.
- lat_sum  out  SUM_W  latency sum of the rd_ch channel.
- txn_count  out  TXN_W  recorded transaction count of the rd_ch channel.
- bin_count  out  BIN_W  histogram bin[rd_bin] of the rd_ch channel.

## Operation
- Per-channel FSM has three states: IDLE, MEAS, TMO.
- IDLE:
  - start=1: go to MEAS, cnt←0.
  - done=1 with start=0: set proto_err, stay in IDLE.
- MEAS:
  - Each cycle cnt←cnt+1, saturating.
  - done=1: record cnt+1 as the latency, then go to IDLE.
  - start=1 with done=0: set proto_err. The running measurement continues.
  - cnt+1 == TIMEOUT with no done: go to TMO and set timeout_flag. Nothing is recorded.
- TMO:
  - Waits for the late done, discards it, then goes to IDLE.
  - start in TMO is ignored and sets proto_err.
- Record of latency L:
  - lat_min←min(lat_min, L); lat_max←max(lat_max, L).
  - lat_sum←lat_sum+L, saturating; txn_count+1, saturating.
  - bin[min(L, NBINS-1)] increments, saturating.
  - last_lat←L; last_valid pulses for one cycle.
- Channels are fully independent. Simultaneous records on different channels all take effect in the same cycle.
- Readback is combinational from registers. rd_ch ≥ NCH returns all-zero statistics.
- Priority: rst over clear over start/done. A start or done coincident with clear is dropped.

## Timing
- Latency definition: start sampled high at posedge k and done sampled high at posedge k+L gives latency L (L ≥ 1).
- Record takes effect at posedge k+L. Statistics and last_valid are visible in the following cycle.
- timeout_flag rises after the posedge at which TIMEOUT cycles have elapsed since start without done.
- Reset values, and values after clear:
  - lat_min = all-ones, lat_max = 0, lat_sum = 0, txn_count = 0.
  - All bins = 0, last_lat = 0.
  - mon_busy = 0, timeout_flag = 0, proto_err = 0, last_valid = 0.
  - All FSMs in IDLE.
- Reset or clear during MEAS abandons the measurement. No record is made.

## Configuration
- AES_LAT_HIST_EN defined: the NCH×NBINS histogram storage is built and bin_count is live.
- AES_LAT_HIST_EN undefined: no histogram registers are built and bin_count is tied to 0. All other behaviour is identical.

## Test plan
- Single latency: NCH=1, start at cycle 0, done 11 cycles later. Required: lat_min=lat_max=11, lat_sum=11, txn_count=1, bin[11]=1, one last_valid pulse with last_lat=11.
- Timeout: TIMEOUT=20, start with no done. Required: timeout_flag=1 after 20 cycles, txn_count=0. A late done then returns the FSM to IDLE with no record.
- Overflow bin: NBINS=64, latencies 70 and 63 recorded. Required: bin[63]=2, lat_max=70, lat_sum=133.
- Two channels: NCH=2, latencies 11 and 14 with both done pulses in the same cycle. Required: each channel's stats are correct independently, and rd_ch=2 returns zeros.
- Protocol errors:
  - done while IDLE sets proto_err.
  - start during MEAS sets proto_err, and the original measurement still records its correct latency.
- Abort and configuration:
  - clear or rst at cycle 5 of a measurement: all statistics are back at reset values and the later done only sets proto_err.
  - Rebuild without AES_LAT_HIST_EN: bin_count=0 and all other statistics are unchanged.

Source files
------------

// File: rtl/aes_lat_monitor.sv
// Start/done latency monitor: per-channel min/max/sum/count, sticky timeout and protocol flags.
// Define AES_LAT_HIST_EN to build the per-channel latency histogram; otherwise bin_count reads 0.
module aes_lat_monitor #(
  parameter int NCH     = 1,
  parameter int CNT_W   = 16,
  parameter int SUM_W   = 32,
  parameter int TXN_W   = 16,
  parameter int NBINS   = 64,
  parameter int BIN_W   = 16,
  parameter int TIMEOUT = 2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             start,
  input  logic [NCH-1:0]             done,
  input  logic                       clear,
  input  logic [$clog2(NCH):0]       rd_ch,
  input  logic [$clog2(NBINS)-1:0]   rd_bin,
  output logic [NCH-1:0]             mon_busy,
  output logic [NCH-1:0]             timeout_flag,
  output logic [NCH-1:0]             proto_err,
  output logic [NCH-1:0]             last_valid,
  output logic [NCH*CNT_W-1:0]       last_lat,
  output logic [CNT_W-1:0]           lat_min,
  output logic [CNT_W-1:0]           lat_max,
  output logic [SUM_W-1:0]           lat_sum,
  output logic [TXN_W-1:0]           txn_count,
  output logic [BIN_W-1:0]           bin_count
);

  localparam int RCH_W = $clog2(NCH) + 1;
  localparam int ACC_W = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
  localparam logic [CNT_W-1:0] TMO_LAT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEAS, TMO} state_t;

  logic [CNT_W-1:0] min_a [NCH];
  logic [CNT_W-1:0] max_a [NCH];
  logic [SUM_W-1:0] sum_a [NCH];
  logic [TXN_W-1:0] txn_a [NCH];
  logic [BIN_W-1:0] bin_a [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [CNT_W-1:0] min_r, max_r, last_r;
    logic [SUM_W-1:0] sum_r, sum_nxt;
    logic [ACC_W-1:0] sum_ext;
    logic [TXN_W-1:0] txn_r;
    logic             busy_r, tmo_r, perr_r, lv_r;
    logic             rec;

    // cnt_inc is both the next count and the latency recorded on done
    always_comb begin
      cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      sum_ext = ACC_W'(sum_r) + ACC_W'(cnt_inc);
      sum_nxt = (sum_ext > ACC_W'({SUM_W{1'b1}})) ? '1 : sum_ext[SUM_W-1:0];
      rec     = (state == MEAS) && done[i] && !clear;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= IDLE;
        cnt    <= '0;
        min_r  <= '1;
        max_r  <= '0;
        sum_r  <= '0;
        txn_r  <= '0;
        last_r <= '0;
        busy_r <= 1'b0;
        tmo_r  <= 1'b0;
        perr_r <= 1'b0;
        lv_r   <= 1'b0;
      end else if (clear) begin
        state  <= IDLE;
        cnt    <= '0;
        min_r  <= '1;
        max_r  <= '0;
        sum_r  <= '0;
        txn_r  <= '0;
        last_r <= '0;
        busy_r <= 1'b0;
        tmo_r  <= 1'b0;
        perr_r <= 1'b0;
        lv_r   <= 1'b0;
      end else begin
        lv_r <= 1'b0;
        case (state)
          IDLE: begin
            if (start[i]) begin
              state  <= MEAS;
              cnt    <= '0;
              busy_r <= 1'b1;
            end else if (done[i]) begin
              perr_r <= 1'b1;
            end
          end
          MEAS: begin
            if (rec) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              lv_r   <= 1'b1;
              last_r <= cnt_inc;
              sum_r  <= sum_nxt;
              if (cnt_inc < min_r) min_r <= cnt_inc;
              if (cnt_inc > max_r) max_r <= cnt_inc;
              if (txn_r != '1) txn_r <= txn_r + TXN_W'(1);
            end else begin
              cnt <= cnt_inc;
              if (start[i]) perr_r <= 1'b1;
              if (cnt_inc == TMO_LAT) begin
                state  <= TMO;
                busy_r <= 1'b0;
                tmo_r  <= 1'b1;
              end
            end
          end
          TMO: begin
            // the late done is swallowed here so it is not flagged as a protocol error
            if (start[i]) perr_r <= 1'b1;
            if (done[i]) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end

`ifdef AES_LAT_HIST_EN
    logic [BIN_W-1:0]           hist [NBINS];
    logic [$clog2(NBINS)-1:0]   bin_idx;

    always_comb begin
      bin_idx = (cnt_inc >= CNT_W'(NBINS - 1)) ? ($clog2(NBINS))'(NBINS - 1)
                                                : ($clog2(NBINS))'(cnt_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int b = 0; b < NBINS; b++) hist[b] <= '0;
      end else if (clear) begin
        for (int b = 0; b < NBINS; b++) hist[b] <= '0;
      end else if (rec && (hist[bin_idx] != '1)) begin
        hist[bin_idx] <= hist[bin_idx] + BIN_W'(1);
      end
    end

    assign bin_a[i] = hist[rd_bin];
`else
    assign bin_a[i] = '0;
`endif

    assign min_a[i] = min_r;
    assign max_a[i] = max_r;
    assign sum_a[i] = sum_r;
    assign txn_a[i] = txn_r;
    assign mon_busy[i]     = busy_r;
    assign timeout_flag[i] = tmo_r;
    assign proto_err[i]    = perr_r;
    assign last_valid[i]   = lv_r;
    assign last_lat[i*CNT_W +: CNT_W] = last_r;
  end

`ifndef AES_LAT_HIST_EN
  logic unused_rd_bin;
  assign unused_rd_bin = ^rd_bin;
`endif

  // out-of-range channel selects read back as all zeros, including lat_min
  always_comb begin
    lat_min   = '0;
    lat_max   = '0;
    lat_sum   = '0;
    txn_count = '0;
    bin_count = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == RCH_W'(c)) begin
        lat_min   = min_a[c];
        lat_max   = max_a[c];
        lat_sum   = sum_a[c];
        txn_count = txn_a[c];
        bin_count = bin_a[c];
      end
    end
  end

endmodule

// File: tb/tb_aes_lat_monitor.sv
// Bench for aes_lat_monitor: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized start/done traffic.
module tb_aes_lat_monitor;
  localparam int NCH     = 2;
  localparam int CNT_W   = 16;
  localparam int SUM_W   = 12;
  localparam int TXN_W   = 6;
  localparam int NBINS   = 64;
  localparam int BIN_W   = 4;
  localparam int TIMEOUT = 80;
`ifdef AES_LAT_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif
  localparam longint SUM_MAX = (64'd1 << SUM_W) - 1;
  localparam longint TXN_MAX = (64'd1 << TXN_W) - 1;
  localparam longint BIN_MAX = (64'd1 << BIN_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] start, done;
  logic clear;
  logic [1:0] rd_ch;
  logic [5:0] rd_bin;
  logic [NCH-1:0] mon_busy, timeout_flag, proto_err, last_valid;
  logic [NCH*CNT_W-1:0] last_lat;
  logic [CNT_W-1:0] lat_min, lat_max;
  logic [SUM_W-1:0] lat_sum;
  logic [TXN_W-1:0] txn_count;
  logic [BIN_W-1:0] bin_count;

  aes_lat_monitor #(
    .NCH(NCH), .CNT_W(CNT_W), .SUM_W(SUM_W), .TXN_W(TXN_W),
    .NBINS(NBINS), .BIN_W(BIN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .clear(clear),
    .rd_ch(rd_ch), .rd_bin(rd_bin),
    .mon_busy(mon_busy), .timeout_flag(timeout_flag), .proto_err(proto_err),
    .last_valid(last_valid), .last_lat(last_lat),
    .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
    .txn_count(txn_count), .bin_count(bin_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (timestamps, not counters) ----------------
  longint now = 0;
  int     m_mode [NCH];          // 0 idle, 1 measuring, 2 waiting for late done
  longint m_t0   [NCH];
  longint m_min  [NCH], m_max [NCH], m_sum [NCH], m_cnt [NCH], m_last [NCH];
  bit     m_lv   [NCH], m_perr [NCH], m_tflag [NCH];
  longint m_bin  [NCH][NBINS];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_t0[c] = 0;
      m_min[c] = (64'd1 << CNT_W) - 1; m_max[c] = 0; m_sum[c] = 0; m_cnt[c] = 0;
      m_last[c] = 0; m_lv[c] = 0; m_perr[c] = 0; m_tflag[c] = 0;
      for (int b = 0; b < NBINS; b++) m_bin[c][b] = 0;
    end
  endfunction

  function automatic void model_record(int c, longint lat);
    int b;
    if (lat < m_min[c]) m_min[c] = lat;
    if (lat > m_max[c]) m_max[c] = lat;
    m_sum[c] = (m_sum[c] + lat > SUM_MAX) ? SUM_MAX : m_sum[c] + lat;
    m_cnt[c] = (m_cnt[c] + 1 > TXN_MAX) ? TXN_MAX : m_cnt[c] + 1;
    b = (lat > NBINS - 1) ? NBINS - 1 : int'(lat);
    m_bin[c][b] = (m_bin[c][b] + 1 > BIN_MAX) ? BIN_MAX : m_bin[c][b] + 1;
    m_last[c] = lat;
    m_lv[c] = 1;
  endfunction

  function automatic void model_step(logic [NCH-1:0] st, logic [NCH-1:0] dn, logic clr);
    longint lat;
    now++;
    if (clr) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      m_lv[c] = 0;
      if (m_mode[c] == 0) begin
        if (st[c]) begin m_mode[c] = 1; m_t0[c] = now; end
        else if (dn[c]) m_perr[c] = 1;
      end else if (m_mode[c] == 1) begin
        lat = now - m_t0[c];
        if (dn[c]) begin
          model_record(c, lat);
          m_mode[c] = 0;
        end else begin
          if (st[c]) m_perr[c] = 1;
          if (lat == TIMEOUT) begin m_mode[c] = 2; m_tflag[c] = 1; end
        end
      end else begin
        if (st[c]) m_perr[c] = 1;
        if (dn[c]) m_mode[c] = 0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_busy, e_tf, e_pe, e_lv;
    logic [NCH*CNT_W-1:0] e_last;
    longint e_min, e_max, e_sum, e_cnt, e_bin;
    for (int c = 0; c < NCH; c++) begin
      e_busy[c] = (m_mode[c] == 1);
      e_tf[c] = m_tflag[c];
      e_pe[c] = m_perr[c];
      e_lv[c] = m_lv[c];
      e_last[c*CNT_W +: CNT_W] = CNT_W'(m_last[c]);
    end
    if (rd_ch < NCH) begin
      e_min = m_min[rd_ch]; e_max = m_max[rd_ch]; e_sum = m_sum[rd_ch];
      e_cnt = m_cnt[rd_ch]; e_bin = HIST ? m_bin[rd_ch][rd_bin] : 0;
    end else begin
      e_min = 0; e_max = 0; e_sum = 0; e_cnt = 0; e_bin = 0;
    end
    check("mon_busy", 64'(mon_busy), 64'(e_busy));
    check("timeout_flag", 64'(timeout_flag), 64'(e_tf));
    check("proto_err", 64'(proto_err), 64'(e_pe));
    check("last_valid", 64'(last_valid), 64'(e_lv));
    check("last_lat", 64'(last_lat), 64'(e_last));
    check("lat_min", 64'(lat_min), e_min);
    check("lat_max", 64'(lat_max), e_max);
    check("lat_sum", 64'(lat_sum), e_sum);
    check("txn_count", 64'(txn_count), e_cnt);
    check("bin_count", 64'(bin_count), e_bin);
  endtask

  // model advances on each posedge; DUT compared at the following negedge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(start, done, clear);
      @(negedge clk);
      if (rst) model_reset();
      compare_all();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [NCH-1:0] st, input logic [NCH-1:0] dn, input logic clr);
    start = st; done = dn; clear = clr;
    @(posedge clk); #2;
    start = '0; done = '0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic rd(input int ch, input int bin);
    rd_ch = 2'(ch); rd_bin = 6'(bin);
    #1;
  endtask

  // latency L on channel 0: start sampled at edge k, done at edge k+L
  task automatic txn0(input int lat);
    cyc(2'b01, 2'b00, 1'b0);
    idle(lat - 1);
    cyc(2'b00, 2'b01, 1'b0);
  endtask

  task automatic rand_cycle(input int pd, input int pclr);
    logic [NCH-1:0] st, dn;
    logic c;
    for (int ch = 0; ch < NCH; ch++) begin
      if (m_mode[ch] == 0) begin
        st[ch] = ($urandom_range(0, 7) == 0);
        dn[ch] = ($urandom_range(0, 299) == 0);
      end else if (m_mode[ch] == 1) begin
        st[ch] = ($urandom_range(0, 199) == 0);
        dn[ch] = ($urandom_range(0, pd - 1) == 0);
      end else begin
        st[ch] = ($urandom_range(0, 49) == 0);
        dn[ch] = ($urandom_range(0, 9) == 0);
      end
    end
    c = (pclr != 0) && ($urandom_range(0, pclr - 1) == 0);
    rd_ch = 2'($urandom_range(0, 3));
    rd_bin = 6'($urandom_range(0, 63));
    cyc(st, dn, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = '0; done = '0; clear = 1'b0; rd_ch = '0; rd_bin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    rd(0, 0);
    check("rst_lat_min", 64'(lat_min), 64'hFFFF);
    check("rst_lat_max", 64'(lat_max), 0);
    check("rst_txn", 64'(txn_count), 0);
    check("rst_busy", 64'(mon_busy), 0);

    // single latency of 11
    txn0(11);
    rd(0, 11);
    check("single_lv", 64'(last_valid), 1);
    check("single_last", 64'(last_lat[CNT_W-1:0]), 11);
    check("single_min", 64'(lat_min), 11);
    check("single_max", 64'(lat_max), 11);
    check("single_sum", 64'(lat_sum), 11);
    check("single_txn", 64'(txn_count), 1);
    check("single_bin", 64'(bin_count), HIST ? 1 : 0);
    idle(1);
    check("single_lv_drop", 64'(last_valid), 0);

    // timeout, then a late done that is discarded
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 1'b0);
    idle(TIMEOUT - 1);
    rd(0, 0);
    check("tmo_not_yet", 64'(timeout_flag), 0);
    check("tmo_busy", 64'(mon_busy), 1);
    idle(1);
    check("tmo_flag", 64'(timeout_flag), 1);
    check("tmo_txn", 64'(txn_count), 0);
    idle(5);
    cyc(2'b00, 2'b01, 1'b0);
    check("tmo_late_txn", 64'(txn_count), 0);
    check("tmo_late_perr", 64'(proto_err), 0);
    txn0(6);
    check("tmo_after_txn", 64'(txn_count), 1);
    check("tmo_after_min", 64'(lat_min), 6);

    // overflow bin
    cyc(2'b00, 2'b00, 1'b1);
    txn0(70);
    txn0(63);
    rd(0, 63);
    check("ovf_bin", 64'(bin_count), HIST ? 2 : 0);
    check("ovf_max", 64'(lat_max), 70);
    check("ovf_min", 64'(lat_min), 63);
    check("ovf_sum", 64'(lat_sum), 133);

    // two channels finishing together: ch1 latency 14, ch0 latency 11
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b10, 2'b00, 1'b0);
    idle(2);
    cyc(2'b01, 2'b00, 1'b0);
    idle(10);
    cyc(2'b00, 2'b11, 1'b0);
    rd(0, 11);
    check("pair_lv", 64'(last_valid), 3);
    check("pair_last", 64'(last_lat), {32'd0, 16'd14, 16'd11});
    check("pair_min0", 64'(lat_min), 11);
    check("pair_bin0", 64'(bin_count), HIST ? 1 : 0);
    rd(1, 14);
    check("pair_min1", 64'(lat_min), 14);
    check("pair_sum1", 64'(lat_sum), 14);
    check("pair_bin1", 64'(bin_count), HIST ? 1 : 0);
    rd(2, 14);
    check("pair_rd2_min", 64'(lat_min), 0);
    check("pair_rd2_txn", 64'(txn_count), 0);

    // protocol errors
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b01, 1'b0);
    check("perr_done_idle", 64'(proto_err), 1);
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 1'b0);
    idle(3);
    cyc(2'b01, 2'b00, 1'b0);
    check("perr_start_meas", 64'(proto_err), 1);
    idle(3);
    cyc(2'b00, 2'b01, 1'b0);
    rd(0, 8);
    check("perr_meas_lat", 64'(last_lat[CNT_W-1:0]), 8);
    check("perr_meas_txn", 64'(txn_count), 1);

    // clear at cycle 5 of a measurement
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 1'b0);
    idle(4);
    cyc(2'b00, 2'b00, 1'b1);
    check("clr_abort_busy", 64'(mon_busy), 0);
    idle(3);
    cyc(2'b00, 2'b01, 1'b0);
    rd(0, 0);
    check("clr_abort_perr", 64'(proto_err), 1);
    check("clr_abort_txn", 64'(txn_count), 0);
    check("clr_abort_min", 64'(lat_min), 64'hFFFF);

    // reset at cycle 5 of a measurement
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 1'b0);
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    cyc(2'b00, 2'b01, 1'b0);
    check("rst_abort_perr", 64'(proto_err), 1);
    check("rst_abort_txn", 64'(txn_count), 0);
    check("rst_abort_lv", 64'(last_valid), 0);

    // start coincident with clear is dropped
    cyc(2'b11, 2'b00, 1'b1);
    check("clr_start_drop", 64'(mon_busy), 0);

    // random traffic: saturation phase, then timeout/clear phase
    for (int n = 0; n < 8000; n++) rand_cycle(25, 0);
    for (int n = 0; n < 2500; n++) rand_cycle(150, 400);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
